// File: rtl/fetch_sequencer.sv
// fetch_sequencer: one-at-a-time instruction fetch with PC write-back, decode handshake and branch redirect
module fetch_sequencer #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc,
    output logic               pc_write,
    output logic [ADDR_W-1:0]  next_pc,
    output logic               imem_req_valid,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               instr_ready,
    output logic               fetch_err
);
    typedef enum logic [2:0] {S_RST, S_INIT, S_REQ, S_WAIT, S_HOLD, S_DRAIN, S_ERR} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
    logic               instr_valid_q, instr_valid_d;
    logic [INSTR_W-1:0] instr_data_q, instr_data_d;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_d;
    logic               fetch_err_q, fetch_err_d;
    logic               redir;

    assign redir       = redirect_valid && (state_q == S_REQ || state_q == S_WAIT ||
                                            state_q == S_HOLD || state_q == S_DRAIN);
    assign instr_valid = instr_valid_q;
    assign instr_data  = instr_data_q;
    assign instr_pc    = instr_pc_q;
    assign fetch_err   = fetch_err_q;

    // next state and combinational PC/request outputs; a redirect overrides whatever the state chose
    always_comb begin
        state_d        = state_q;
        req_pc_d       = req_pc_q;
        instr_valid_d  = instr_valid_q;
        instr_data_d   = instr_data_q;
        instr_pc_d     = instr_pc_q;
        fetch_err_d    = fetch_err_q;
        pc_write       = 1'b0;
        next_pc        = '0;
        imem_req_valid = 1'b0;
        imem_req_addr  = '0;
        case (state_q)
            S_RST:   state_d = S_INIT;
            S_INIT: begin
                pc_write = 1'b1;
                next_pc  = RESET_PC;
                state_d  = S_REQ;
            end
            S_REQ: begin
                imem_req_valid = 1'b1;
                imem_req_addr  = pc;
                if (imem_req_ready) begin
                    req_pc_d = pc;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    instr_data_d  = imem_rsp_data;
                    instr_pc_d    = req_pc_q;
                    instr_valid_d = 1'b1;
                    pc_write      = 1'b1;
                    next_pc       = req_pc_q + ADDR_W'(4);
                    state_d       = S_HOLD;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    state_d       = S_REQ;
                end
            end
            S_DRAIN: state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
            default: state_d = state_q;
        endcase
        if (redir) begin
            pc_write       = 1'b0;
            next_pc        = '0;
            imem_req_valid = 1'b0;
            imem_req_addr  = '0;
            req_pc_d       = req_pc_q;
            instr_valid_d  = 1'b0;
            instr_data_d   = instr_data_q;
            instr_pc_d     = instr_pc_q;
            if (redirect_pc[1:0] != 2'b00) begin
                fetch_err_d  = 1'b1;
                instr_data_d = '0;
                instr_pc_d   = '0;
                state_d      = S_ERR;
            end else begin
                pc_write = 1'b1;
                next_pc  = redirect_pc;
                state_d  = ((state_q == S_WAIT && !imem_rsp_valid) || state_q == S_DRAIN) ? S_DRAIN : S_REQ;
            end
        end
    end

    // state and registered outputs, cleared asynchronously while reset is low
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_RST;
            req_pc_q      <= '0;
            instr_valid_q <= 1'b0;
            instr_data_q  <= '0;
            instr_pc_q    <= '0;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_pc_q      <= req_pc_d;
            instr_valid_q <= instr_valid_d;
            instr_data_q  <= instr_data_d;
            instr_pc_q    <= instr_pc_d;
            fetch_err_q   <= fetch_err_d;
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed vector table, wrap/reset sequence and randomized scoreboard for fetch_sequencer
module tb_fetch_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] f(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic        rst0_n, pw0, rqv0, rdy0, rsv0, rv0, iv0, ir0, err0;
    logic [31:0] pc0, npc0, rad0, rsd0, rpc0, idat0, ipc0;
    logic        man, m_rsv;
    logic [31:0] m_rsd;
    logic        mem_v, mem_busy;
    logic [31:0] mem_d, mem_a;
    logic [1:0]  mem_cnt, mem_lat;

    assign rsv0 = man ? m_rsv : mem_v;
    assign rsd0 = man ? m_rsd : mem_d;

    fetch_sequencer dut0 (
        .clk(clk), .reset(rst0_n), .pc(pc0), .pc_write(pw0), .next_pc(npc0),
        .imem_req_valid(rqv0), .imem_req_addr(rad0), .imem_req_ready(rdy0),
        .imem_rsp_valid(rsv0), .imem_rsp_data(rsd0),
        .redirect_valid(rv0), .redirect_pc(rpc0),
        .instr_valid(iv0), .instr_data(idat0), .instr_pc(ipc0), .instr_ready(ir0),
        .fetch_err(err0)
    );

    // program counter written by dut0
    always @(posedge clk or negedge rst0_n)
        if (!rst0_n) pc0 <= 32'h0;
        else if (pw0) pc0 <= npc0;

    // instruction memory for dut0 with 1..3 cycle response latency
    always @(posedge clk or negedge rst0_n) begin
        if (!rst0_n) begin
            mem_v <= 1'b0; mem_busy <= 1'b0; mem_cnt <= 2'd0; mem_a <= 32'h0; mem_d <= 32'h0; mem_lat <= 2'd1;
        end else begin
            mem_v   <= 1'b0;
            mem_lat <= 2'($urandom_range(1, 3));
            if (rqv0 && rdy0) begin
                if (mem_lat == 2'd1) begin
                    mem_v <= 1'b1; mem_d <= f(rad0);
                end else begin
                    mem_busy <= 1'b1; mem_cnt <= mem_lat - 2'd1; mem_a <= rad0;
                end
            end else if (mem_busy) begin
                if (mem_cnt == 2'd1) begin
                    mem_v <= 1'b1; mem_d <= f(mem_a); mem_busy <= 1'b0;
                end else mem_cnt <= mem_cnt - 2'd1;
            end
        end
    end

    logic        rst1_n, pw1, rqv1, iv1, err1;
    logic        rsv1 = 1'b0;
    logic [31:0] pc1, npc1, rad1, idat1, ipc1;
    logic [31:0] rsd1 = 32'h0;

    fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .reset(rst1_n), .pc(pc1), .pc_write(pw1), .next_pc(npc1),
        .imem_req_valid(rqv1), .imem_req_addr(rad1), .imem_req_ready(1'b1),
        .imem_rsp_valid(rsv1), .imem_rsp_data(rsd1),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .instr_valid(iv1), .instr_data(idat1), .instr_pc(ipc1), .instr_ready(1'b1),
        .fetch_err(err1)
    );

    // program counter written by dut1
    always @(posedge clk or negedge rst1_n)
        if (!rst1_n) pc1 <= 32'h0;
        else if (pw1) pc1 <= npc1;

    // always-ready memory for dut1, answers the cycle after each request
    always @(posedge clk) begin
        rsv1 <= rqv1;
        rsd1 <= f(rad1);
    end

    typedef struct {
        logic rdy, rsp; logic [31:0] dat; logic ir, rv; logic [31:0] rpc;
        logic pw; logic [31:0] npc; logic rqv; logic [31:0] rad;
        logic iv; logic [31:0] ipc, idat; logic err;
    } vec_t;

    function automatic vec_t mk(input logic rdy, rsp, input logic [31:0] dat, input logic ir, rv,
                                input logic [31:0] rpc, input logic pw, input logic [31:0] npc,
                                input logic rqv, input logic [31:0] rad, input logic iv,
                                input logic [31:0] ipc, idat, input logic err);
        vec_t v;
        v.rdy = rdy; v.rsp = rsp; v.dat = dat; v.ir = ir; v.rv = rv; v.rpc = rpc;
        v.pw = pw; v.npc = npc; v.rqv = rqv; v.rad = rad; v.iv = iv; v.ipc = ipc; v.idat = idat; v.err = err;
        return v;
    endfunction

    vec_t tv[26];

    initial begin
        logic [31:0] exp_pc, pv_ipc, pv_idat;
        logic        pv_iv, pv_ir, pv_rv;
        int          delivered;
        tv[0]  = mk(1,0,0,1,0,0,            0,0,0,0,          0,0,0,0);
        tv[1]  = mk(1,0,0,1,0,0,            1,0,0,0,          0,0,0,0);
        tv[2]  = mk(1,0,0,1,0,0,            0,0,1,0,          0,0,0,0);
        tv[3]  = mk(1,1,32'hD000_0000,1,0,0, 1,4,0,0,          0,0,0,0);
        tv[4]  = mk(1,0,0,1,0,0,            0,0,0,0,          1,0,32'hD000_0000,0);
        tv[5]  = mk(1,0,0,1,0,0,            0,0,1,4,          0,0,0,0);
        tv[6]  = mk(1,1,32'hD000_0004,1,0,0, 1,8,0,0,          0,0,0,0);
        for (int k = 7; k < 12; k++)
            tv[k] = mk(1,0,0,0,0,0,         0,0,0,0,          1,4,32'hD000_0004,0);
        tv[12] = mk(1,0,0,1,0,0,            0,0,0,0,          1,4,32'hD000_0004,0);
        tv[13] = mk(1,0,0,1,0,0,            0,0,1,8,          0,0,0,0);
        tv[14] = mk(1,0,0,1,1,32'h100,      1,32'h100,0,0,    0,0,0,0);
        tv[15] = mk(1,1,32'hD000_0008,1,0,0, 0,0,0,0,          0,0,0,0);
        tv[16] = mk(1,0,0,1,0,0,            0,0,1,32'h100,    0,0,0,0);
        tv[17] = mk(1,1,32'hE000_0100,1,0,0, 1,32'h104,0,0,    0,0,0,0);
        tv[18] = mk(1,0,0,1,1,32'h200,      1,32'h200,0,0,    1,32'h100,32'hE000_0100,0);
        tv[19] = mk(0,0,0,1,0,0,            0,0,1,32'h200,    0,0,0,0);
        tv[20] = mk(1,0,0,1,0,0,            0,0,1,32'h200,    0,0,0,0);
        tv[21] = mk(1,1,32'hE000_0200,1,0,0, 1,32'h204,0,0,    0,0,0,0);
        tv[22] = mk(1,0,0,1,0,0,            0,0,0,0,          1,32'h200,32'hE000_0200,0);
        tv[23] = mk(1,0,0,1,1,32'h102,      0,0,0,0,          0,0,0,0);
        tv[24] = mk(1,1,32'hDEAD_BEEF,1,1,32'h300, 0,0,0,0,   0,0,0,1);
        tv[25] = mk(1,0,0,0,0,0,            0,0,0,0,          0,0,0,1);

        rst0_n = 1'b0; rst1_n = 1'b0; man = 1'b1; m_rsv = 1'b0; m_rsd = 32'h0;
        rdy0 = 1'b0; rv0 = 1'b0; rpc0 = 32'h0; ir0 = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("in reset pc_write", pw0, 0);
        chk("in reset req_valid", rqv0, 0);
        chk("in reset instr_valid", iv0, 0);

        @(negedge clk);
        rst0_n = 1'b1;
        for (int k = 0; k < 26; k++) begin
            rdy0 = tv[k].rdy; m_rsv = tv[k].rsp; m_rsd = tv[k].dat;
            ir0 = tv[k].ir; rv0 = tv[k].rv; rpc0 = tv[k].rpc;
            #1;
            chk($sformatf("row%0d pc_write", k), pw0, tv[k].pw);
            chk($sformatf("row%0d next_pc", k), npc0, tv[k].npc);
            chk($sformatf("row%0d req_valid", k), rqv0, tv[k].rqv);
            if (tv[k].rqv) chk($sformatf("row%0d req_addr", k), rad0, tv[k].rad);
            chk($sformatf("row%0d instr_valid", k), iv0, tv[k].iv);
            chk($sformatf("row%0d fetch_err", k), err0, tv[k].err);
            if (tv[k].iv || tv[k].err) begin
                chk($sformatf("row%0d instr_pc", k), ipc0, tv[k].ipc);
                chk($sformatf("row%0d instr_data", k), idat0, tv[k].idat);
            end
            @(negedge clk);
        end
        rst0_n = 1'b0;
        #1;
        chk("err cleared by reset", err0, 0);
        chk("reset in err pc_write", pw0, 0);

        @(negedge clk);
        rst1_n = 1'b1;
        #1 chk("wrap RST pc_write", pw1, 0);
        @(negedge clk); #1;
        chk("wrap INIT pc_write", pw1, 1);
        chk("wrap INIT next_pc", npc1, 32'hFFFF_FFFC);
        @(negedge clk); #1;
        chk("wrap REQ valid", rqv1, 1);
        chk("wrap REQ addr", rad1, 32'hFFFF_FFFC);
        @(negedge clk); #1;
        chk("wrap WAIT pc_write", pw1, 1);
        chk("wrap WAIT next_pc", npc1, 32'h0);
        @(negedge clk); #1;
        chk("wrap HOLD valid", iv1, 1);
        chk("wrap HOLD instr_pc", ipc1, 32'hFFFF_FFFC);
        chk("wrap HOLD instr_data", idat1, f(32'hFFFF_FFFC));
        chk("wrap no error", err1, 0);
        @(negedge clk); #1;
        chk("wrap second req valid", rqv1, 1);
        chk("wrap second req addr", rad1, 32'h0);
        @(negedge clk); #1;
        chk("second WAIT pc_write", pw1, 1);
        chk("second WAIT next_pc", npc1, 32'h4);
        rst1_n = 1'b0;
        #1;
        chk("async reset pc_write", pw1, 0);
        chk("async reset next_pc", npc1, 0);
        chk("async reset req_valid", rqv1, 0);
        chk("async reset instr_valid", iv1, 0);
        chk("async reset instr_pc", ipc1, 0);
        chk("async reset fetch_err", err1, 0);
        repeat (2) @(negedge clk);
        rst1_n = 1'b1;
        #1 chk("restart RST pc_write", pw1, 0);
        @(negedge clk); #1;
        chk("restart INIT next_pc", npc1, 32'hFFFF_FFFC);
        @(negedge clk); #1;
        chk("restart REQ addr", rad1, 32'hFFFF_FFFC);

        man = 1'b0;
        rv0 = 1'b0; rdy0 = 1'b0; ir0 = 1'b0;
        repeat (2) @(negedge clk);
        rst0_n = 1'b1;
        exp_pc = 32'h0; delivered = 0;
        pv_iv = 1'b0; pv_ir = 1'b0; pv_rv = 1'b0; pv_ipc = 32'h0; pv_idat = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            rdy0 = ($urandom_range(0, 9) < 7);
            ir0  = ($urandom_range(0, 9) < 7);
            rv0  = (c > 4) && ($urandom_range(0, 29) == 0);
            rpc0 = (c % 500 == 250) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_0FFC);
            #1;
            if (pv_iv && !pv_ir && !pv_rv) begin
                chk("rand hold valid", iv0, 1);
                chk("rand hold instr_pc", ipc0, pv_ipc);
                chk("rand hold instr_data", idat0, pv_idat);
            end
            if (iv0 && ir0) begin
                chk("rand instr_pc", ipc0, exp_pc);
                chk("rand instr_data", idat0, f(ipc0));
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (rv0) exp_pc = rpc0;
            if (rqv0) chk("rand req_addr", rad0, pc0);
            if (!pw0) chk("rand idle next_pc", npc0, 0);
            chk("rand fetch_err", err0, 0);
            pv_iv = iv0; pv_ir = ir0; pv_rv = rv0; pv_ipc = ipc0; pv_idat = idat0;
            @(negedge clk);
        end
        chk("rand delivered at least 100", 64'(delivered >= 100), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
